global_buffer_bank: RTL and testbench
=====================================

GLOBAL_BUFFER_BANK -- requirements
Module: global_buffer_bank

Interface
REQ-001 The module SHALL have parameter dataSize, default 8, meaning the bits per element.
REQ-002 The module SHALL have parameter interfaceDepth, default 16, meaning the elements per word; the word width W = interfaceDepth*dataSize = 128.
REQ-003 The module SHALL have parameter addrWidth, default 32, meaning the width of the start-address inputs.
REQ-004 The module SHALL have parameter bufferDepth, default 256, meaning the number of words stored; it SHALL be a power of two, and A = log2(bufferDepth).
REQ-005 The module SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-006 The module SHALL have port clk, input, 1 bit: the clock.
REQ-007 The module SHALL have port rst, input, 1 bit: the synchronous active-high reset.
REQ-008 The module SHALL have port instr_i, input, 4 bits: a global_buffer_instruction_t.
REQ-009 The module SHALL have port instr_valid_i, input, 1 bit: the instruction strobe.
REQ-010 The module SHALL have port instr_ready_o, output, 1 bit: the module can accept an instruction.
REQ-011 The module SHALL have port weight_start_addr, input, addrWidth bits: the weight region base, in words.
REQ-012 The module SHALL have port activation_start_addr, input, addrWidth bits: the activation region base, in words.
REQ-013 The module SHALL have port rd_len_i, input, A+1 bits: the number of words in a read burst.
REQ-014 The module SHALL have port wr_data, input, W bits: the write word.
REQ-015 The module SHALL have port wr_en, input, 1 bit: the write request.
REQ-016 The module SHALL have port wr_ready_o, output, 1 bit: a write is accepted this cycle.
REQ-017 The module SHALL have port rd_data, output, W bits: the read word.
REQ-018 The module SHALL have port rd_data_valid, output, 1 bit: rd_data is valid this cycle.

Function
REQ-019 The module SHALL implement the bufferSide end of the global-buffer data interface, responding to an outSide writer/reader.
REQ-020 The module SHALL have exactly these states: IDLE, LOAD (entered for weight, activation and output writes) and READ.
REQ-021 An instruction SHALL be accepted when instr_valid_i && instr_ready_o; instr_ready_o SHALL be 1 in IDLE and LOAD and 0 in READ.
REQ-022 On an accepted I_NOP, the module SHALL go to IDLE with both pointers unchanged.
REQ-023 On an accepted I_POINTER_RESET, the module SHALL set wptr=0 and rptr=0 and go to IDLE.
REQ-024 On an accepted I_LOAD_WEIGHT, the module SHALL set wptr=weight_start_addr[A-1:0] and go to LOAD.
REQ-025 On an accepted I_LOAD_ACTIVATION, the module SHALL set wptr=activation_start_addr[A-1:0] and go to LOAD.
REQ-026 On an accepted I_LOAD_OUTPUT, the module SHALL keep wptr unchanged, so output writes continue from the current pointer, and go to LOAD.
REQ-027 On an accepted I_READ_ACTIVATION, the module SHALL set rptr=activation_start_addr[A-1:0] and remaining=rd_len_i; it SHALL go to READ, or stay in IDLE if rd_len_i==0.
REQ-028 An undefined instruction code SHALL be treated as I_NOP.
REQ-029 wr_ready_o SHALL equal 1 exactly when the state is LOAD.
REQ-030 When wr_en && wr_ready_o, mem[wptr] SHALL be written with wr_data and wptr SHALL be incremented modulo bufferDepth, wrapping from bufferDepth-1 to 0.
REQ-031 wr_en outside LOAD SHALL be ignored, with no write and no pointer change.
REQ-032 If a write and an instruction are accepted in the same cycle, the write SHALL use the old wptr and the instruction's pointer load SHALL take precedence over the increment.
REQ-033 In READ, the module SHALL issue one read per cycle at rptr, then increment rptr (wrapping) and decrement remaining; it SHALL return to IDLE in the cycle after the read that brings remaining to 0.
REQ-034 Read latency SHALL be 1 cycle: rd_data_valid=1 and rd_data=mem[address] in the cycle after each read is issued, and rd_data_valid=0 otherwise.
REQ-035 rd_data SHALL hold its last value when rd_data_valid is 0.
REQ-036 A burst with rd_len_i==bufferDepth SHALL read every word exactly once.
REQ-037 No write can occur during READ, because READ is not LOAD.

Reset
REQ-038 While rst is high at a clock edge, the module SHALL set state=IDLE, wptr=0, rptr=0, remaining=0, rd_data=0, rd_data_valid=0, wr_ready_o=0 (registered-equivalent) and instr_ready_o=1 from the first cycle after reset.
REQ-039 Memory contents SHALL NOT be cleared by reset.
REQ-040 Reset asserted mid-burst SHALL abort the burst, and rd_data_valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-041 When GLB_OVERFLOW_FLAG_EN is defined, the module SHALL have an extra output overflow_o (1 bit), reset to 0, set sticky when an accepted write occurs at wptr==bufferDepth-1, and cleared only by rst or I_POINTER_RESET.
REQ-042 When GLB_OVERFLOW_FLAG_EN is not defined, the overflow_o port and its logic SHALL be absent and wrapping SHALL be silent.

Verification
REQ-043 A bench SHALL cover: reset, then I_LOAD_WEIGHT with weight_start_addr=4, then three writes 0xA,0xB,0xC -> mem[4..6]=A,B,C and wptr=7.
REQ-044 A bench SHALL cover: I_LOAD_ACTIVATION with activation_start_addr=16, writes 0x11,0x22, then I_READ_ACTIVATION with rd_len_i=2 -> rd_data_valid high 2 cycles with 0x11 then 0x22; instr_ready_o=0 for 2 cycles.
REQ-045 A bench SHALL cover: activation_start_addr=255, one write 0x1, I_LOAD_OUTPUT, one write 0x2 -> mem[255]=1 and mem[0]=2; overflow_o=1 when GLB_OVERFLOW_FLAG_EN is defined.
REQ-046 A bench SHALL cover: wr_en in IDLE with data 0xFF -> no memory change and wr_ready_o=0.
REQ-047 A bench SHALL cover: rst asserted on the 2nd cycle of an rd_len_i=8 burst -> rd_data_valid=0 in the cycle after the reset edge, state=IDLE, memory intact.
REQ-048 A bench SHALL cover: I_READ_ACTIVATION with rd_len_i=0 -> no rd_data_valid pulse and instr_ready_o remains 1.

Source files
------------

// File: rtl/global_buffer_bank.sv
// global_buffer_bank
//   Buffer-side end of the global-buffer data interface. An external
//   writer/reader issues instructions that position the write or read
//   pointer. It then streams words into the bank, or reads a burst back.
//
//   Instruction codes (global_buffer_instruction_t, 4 bits):
//     0 I_NOP, 1 I_POINTER_RESET, 2 I_LOAD_WEIGHT, 3 I_LOAD_ACTIVATION,
//     4 I_LOAD_OUTPUT, 5 I_READ_ACTIVATION; other codes act as I_NOP.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     instr_i, instr_valid_i   instruction and its strobe
//     instr_ready_o            instruction can be accepted (IDLE/LOAD)
//     weight_start_addr        weight region base (words)
//     activation_start_addr    activation region base (words)
//     rd_len_i                 read burst length in words (0..bufferDepth)
//     wr_data, wr_en           write word and write request
//     wr_ready_o               write accepted this cycle (state LOAD)
//     rd_data, rd_data_valid   read word, valid one cycle after issue
//     overflow_o               only with GLB_OVERFLOW_FLAG_EN: sticky flag
//                              set by a write at the last word address
//
//   Optional feature macro: GLB_OVERFLOW_FLAG_EN
module global_buffer_bank #(
  parameter int dataSize       = 8,
  parameter int interfaceDepth = 16,
  parameter int addrWidth      = 32,
  parameter int bufferDepth    = 256,
  localparam int W = interfaceDepth * dataSize,
  localparam int A = $clog2(bufferDepth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [addrWidth-1:0] weight_start_addr,
  input  logic [addrWidth-1:0] activation_start_addr,
  input  logic [A:0]           rd_len_i,
  input  logic [W-1:0]         wr_data,
  input  logic                 wr_en,
  output logic                 wr_ready_o,
  output logic [W-1:0]         rd_data,
  output logic                 rd_data_valid
`ifdef GLB_OVERFLOW_FLAG_EN
  ,
  output logic                 overflow_o
`endif
);

  typedef enum logic [3:0] {
    I_NOP             = 4'd0,
    I_POINTER_RESET   = 4'd1,
    I_LOAD_WEIGHT     = 4'd2,
    I_LOAD_ACTIVATION = 4'd3,
    I_LOAD_OUTPUT     = 4'd4,
    I_READ_ACTIVATION = 4'd5
  } global_buffer_instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READ
  } state_t;

  state_t       state;
  logic [A-1:0] wptr;
  logic [A-1:0] rptr;
  logic [A:0]   remaining;
  logic [W-1:0] mem [bufferDepth];

  logic instr_accept;
  logic wr_accept;

  // Only the low A bits of the base addresses select a word. The upper bits
  // are folded into this sink so that they count as intentionally unused.
  logic unused_addr_upper;
  assign unused_addr_upper = ^{weight_start_addr[addrWidth-1:A],
                               activation_start_addr[addrWidth-1:A]};

  // Both handshakes are pure decodes of the registered state.
  assign instr_ready_o = (state != READ);
  assign wr_ready_o    = (state == LOAD);
  assign instr_accept  = instr_valid_i && instr_ready_o;
  assign wr_accept     = wr_en && wr_ready_o;

  // Storage array. It has no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wptr] <= wr_data;
    end
  end

  // Control FSM, pointers and read pipeline. The instruction decode comes
  // last. When a write and an instruction land in the same cycle, the
  // write uses the old wptr, and any pointer load overrides the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      remaining     <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
`ifdef GLB_OVERFLOW_FLAG_EN
      overflow_o    <= 1'b0;
`endif
    end else begin
      rd_data_valid <= 1'b0;

      if (wr_accept) begin
        wptr <= wptr + 1'b1;
`ifdef GLB_OVERFLOW_FLAG_EN
        if (&wptr) begin
          overflow_o <= 1'b1;
        end
`endif
      end

      // One read per cycle. The FSM leaves READ after the read that
      // consumes the last remaining word.
      if (state == READ) begin
        rd_data       <= mem[rptr];
        rd_data_valid <= 1'b1;
        rptr          <= rptr + 1'b1;
        remaining     <= remaining - 1'b1;
        if (remaining == (A+1)'(1)) begin
          state <= IDLE;
        end
      end

      if (instr_accept) begin
        case (instr_i)
          I_POINTER_RESET: begin
            wptr  <= '0;
            rptr  <= '0;
            state <= IDLE;
`ifdef GLB_OVERFLOW_FLAG_EN
            overflow_o <= 1'b0;
`endif
          end
          I_LOAD_WEIGHT: begin
            wptr  <= weight_start_addr[A-1:0];
            state <= LOAD;
          end
          I_LOAD_ACTIVATION: begin
            wptr  <= activation_start_addr[A-1:0];
            state <= LOAD;
          end
          I_LOAD_OUTPUT: begin
            state <= LOAD;
          end
          I_READ_ACTIVATION: begin
            rptr      <= activation_start_addr[A-1:0];
            remaining <= rd_len_i;
            state     <= (rd_len_i == '0) ? IDLE : READ;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_global_buffer_bank.sv
// tb_global_buffer_bank
//   Directed testbench for global_buffer_bank in its default configuration
//   (8-bit elements, 16 elements per word, 256 words). It drives
//   instructions and writes, and compares the outputs and selected internal
//   state against hand-computed values.
module tb_global_buffer_bank;

  localparam int W = 128;
  localparam int A = 8;

  localparam logic [3:0] I_NOP             = 4'd0;
  localparam logic [3:0] I_POINTER_RESET   = 4'd1;
  localparam logic [3:0] I_LOAD_WEIGHT     = 4'd2;
  localparam logic [3:0] I_LOAD_ACTIVATION = 4'd3;
  localparam logic [3:0] I_LOAD_OUTPUT     = 4'd4;
  localparam logic [3:0] I_READ_ACTIVATION = 4'd5;

  logic         clk;
  logic         rst;
  logic [3:0]   instr_i;
  logic         instr_valid_i;
  logic         instr_ready_o;
  logic [31:0]  weight_start_addr;
  logic [31:0]  activation_start_addr;
  logic [A:0]   rd_len_i;
  logic [W-1:0] wr_data;
  logic         wr_en;
  logic         wr_ready_o;
  logic [W-1:0] rd_data;
  logic         rd_data_valid;
`ifdef GLB_OVERFLOW_FLAG_EN
  logic         overflow_o;
`endif

  int checkCount;
  int errorCount;

  global_buffer_bank dut (
    .clk                   (clk),
    .rst                   (rst),
    .instr_i               (instr_i),
    .instr_valid_i         (instr_valid_i),
    .instr_ready_o         (instr_ready_o),
    .weight_start_addr     (weight_start_addr),
    .activation_start_addr (activation_start_addr),
    .rd_len_i              (rd_len_i),
    .wr_data               (wr_data),
    .wr_en                 (wr_en),
    .wr_ready_o            (wr_ready_o),
    .rd_data               (rd_data),
    .rd_data_valid         (rd_data_valid)
`ifdef GLB_OVERFLOW_FLAG_EN
    ,
    .overflow_o            (overflow_o)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with the expected value and count it.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 time unit after the
  // edge. That point is a safe place both to sample outputs and to drive
  // the next cycle's inputs.
  task automatic applyStimulus(input logic [3:0] instr, input logic valid,
                               input logic we, input logic [W-1:0] data);
    instr_i       = instr;
    instr_valid_i = valid;
    wr_en         = we;
    wr_data       = data;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    wr_en         = 1'b0;
  endtask

  initial begin
    checkCount            = 0;
    errorCount            = 0;
    rst                   = 1'b1;
    instr_i               = I_NOP;
    instr_valid_i         = 1'b0;
    weight_start_addr     = 32'd0;
    activation_start_addr = 32'd0;
    rd_len_i              = '0;
    wr_data               = '0;
    wr_en                 = 1'b0;

    // Reset state.
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    rst = 1'b0;
    checkOutput("rst_instr_ready", W'(instr_ready_o), W'(1));
    checkOutput("rst_wr_ready", W'(wr_ready_o), W'(0));
    checkOutput("rst_rd_valid", W'(rd_data_valid), W'(0));
    checkOutput("rst_rd_data", rd_data, W'(0));
    checkOutput("rst_wptr", W'(dut.wptr), W'(0));
`ifdef GLB_OVERFLOW_FLAG_EN
    checkOutput("rst_overflow", W'(overflow_o), W'(0));
`endif

    // Load weights at address 4: three writes fill words 4..6.
    weight_start_addr = 32'd4;
    applyStimulus(I_LOAD_WEIGHT, 1'b1, 1'b0, '0);
    checkOutput("lw_wr_ready", W'(wr_ready_o), W'(1));
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'hA));
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'hB));
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'hC));
    checkOutput("lw_mem4", dut.mem[4], W'(128'hA));
    checkOutput("lw_mem5", dut.mem[5], W'(128'hB));
    checkOutput("lw_mem6", dut.mem[6], W'(128'hC));
    checkOutput("lw_wptr", W'(dut.wptr), W'(7));

    // A NOP returns to IDLE. A write request in IDLE is then ignored.
    applyStimulus(I_NOP, 1'b1, 1'b0, '0);
    checkOutput("idle_wr_ready", W'(wr_ready_o), W'(0));
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'hFF));
    checkOutput("idle_wr_mem4", dut.mem[4], W'(128'hA));
    checkOutput("idle_wr_wptr", W'(dut.wptr), W'(7));

    // Load activations at 16, then read two words back.
    activation_start_addr = 32'd16;
    applyStimulus(I_LOAD_ACTIVATION, 1'b1, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'h11));
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'h22));
    rd_len_i = 9'd2;
    applyStimulus(I_READ_ACTIVATION, 1'b1, 1'b0, '0);
    checkOutput("rd2_ready_c0", W'(instr_ready_o), W'(0));
    checkOutput("rd2_valid_c0", W'(rd_data_valid), W'(0));
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("rd2_ready_c1", W'(instr_ready_o), W'(0));
    checkOutput("rd2_valid_c1", W'(rd_data_valid), W'(1));
    checkOutput("rd2_data_c1", rd_data, W'(128'h11));
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("rd2_ready_c2", W'(instr_ready_o), W'(1));
    checkOutput("rd2_valid_c2", W'(rd_data_valid), W'(1));
    checkOutput("rd2_data_c2", rd_data, W'(128'h22));
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("rd2_valid_c3", W'(rd_data_valid), W'(0));
    checkOutput("rd2_data_hold", rd_data, W'(128'h22));

    // A zero-length read produces no valid pulse and keeps the bank ready.
    rd_len_i = 9'd0;
    applyStimulus(I_READ_ACTIVATION, 1'b1, 1'b0, '0);
    checkOutput("rd0_ready", W'(instr_ready_o), W'(1));
    checkOutput("rd0_valid_c0", W'(rd_data_valid), W'(0));
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("rd0_valid_c1", W'(rd_data_valid), W'(0));

    // Write pointer wraps: word 255, then word 0 via LOAD_OUTPUT.
    activation_start_addr = 32'd255;
    applyStimulus(I_LOAD_ACTIVATION, 1'b1, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'h1));
    applyStimulus(I_LOAD_OUTPUT, 1'b1, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b1, W'(128'h2));
    checkOutput("wrap_mem255", dut.mem[255], W'(128'h1));
    checkOutput("wrap_mem0", dut.mem[0], W'(128'h2));
    checkOutput("wrap_wptr", W'(dut.wptr), W'(1));
`ifdef GLB_OVERFLOW_FLAG_EN
    checkOutput("wrap_overflow", W'(overflow_o), W'(1));
`endif
    applyStimulus(I_POINTER_RESET, 1'b1, 1'b0, '0);
    checkOutput("prst_wptr", W'(dut.wptr), W'(0));
    checkOutput("prst_state_idle", W'(wr_ready_o), W'(0));
`ifdef GLB_OVERFLOW_FLAG_EN
    checkOutput("prst_overflow", W'(overflow_o), W'(0));
`endif

    // Reset on the second cycle of an 8-word burst aborts it.
    activation_start_addr = 32'd16;
    rd_len_i = 9'd8;
    applyStimulus(I_READ_ACTIVATION, 1'b1, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("abort_valid_c1", W'(rd_data_valid), W'(1));
    checkOutput("abort_data_c1", rd_data, W'(128'h11));
    rst = 1'b1;
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    rst = 1'b0;
    checkOutput("abort_valid", W'(rd_data_valid), W'(0));
    checkOutput("abort_ready", W'(instr_ready_o), W'(1));
    checkOutput("abort_wr_ready", W'(wr_ready_o), W'(0));
    checkOutput("abort_rptr", W'(dut.rptr), W'(0));
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("abort_valid_after", W'(rd_data_valid), W'(0));
    checkOutput("abort_mem4", dut.mem[4], W'(128'hA));
    checkOutput("abort_mem17", dut.mem[17], W'(128'h22));

    // Memory survives reset: read word 17 back through the port.
    activation_start_addr = 32'd17;
    rd_len_i = 9'd1;
    applyStimulus(I_READ_ACTIVATION, 1'b1, 1'b0, '0);
    applyStimulus(I_NOP, 1'b0, 1'b0, '0);
    checkOutput("post_rst_valid", W'(rd_data_valid), W'(1));
    checkOutput("post_rst_data", rd_data, W'(128'h22));
    checkOutput("post_rst_ready", W'(instr_ready_o), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
